// File: rtl/ib_feeder_pkg.sv
// Shared definitions for the input-buffer feeder and every controller that drives
// the 4-lane input buffer control pins.
package ib_feeder_pkg;

   localparam logic [1:0] CTL_IDLE  = 2'd0;
   localparam logic [1:0] CTL_STORE = 2'd1;
   localparam logic [1:0] CTL_OUT   = 2'd2;
   localparam logic [1:0] CTL_CLEAR = 2'd3;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_VECTOR = 4;
   localparam int DEF_ADDR_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_GAP,
      S_DRAIN,
      S_FIN
   } state_t;

endpackage

// File: rtl/ib_feeder.sv
// Load-side driver for the input buffer: fetches VECTOR words from a synchronous-read
// memory and sequences clear, store burst, gap and optional output burst.
module ib_feeder
   import ib_feeder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int VECTOR = DEF_VECTOR,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              drain,
   input  logic              replay,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WIDTH-1:0]  mem_data,
   output logic [1:0]        ib_ctl,
   output logic [WIDTH-1:0]  ib_in,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(VECTOR + 1);
   localparam logic [CW-1:0] VEC_C = CW'(VECTOR);

   state_t            state_q;
   logic [ADDR_W-1:0] base_q;
   logic              drain_q;
   logic              replay_q;
   logic [CW-1:0]     rd_q;
   logic [CW-1:0]     st_q;
   logic              vld_q;
   logic              mem_rd_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [1:0]        ctl_q;
   logic [WIDTH-1:0]  ib_in_q;
   logic              busy_q;
   logic              done_q;

   // Every output is computed for the cycle that follows the edge, so each branch
   // sets the values of the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         drain_q    <= 1'b0;
         replay_q   <= 1'b0;
         rd_q       <= '0;
         st_q       <= '0;
         vld_q      <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         ctl_q      <= CTL_IDLE;
         ib_in_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         vld_q    <= mem_rd_q;
         mem_rd_q <= 1'b0;
         ctl_q    <= CTL_IDLE;
         ib_in_q  <= '0;
         done_q   <= 1'b0;

         if ((state_q == S_CLEAR || state_q == S_LOAD) && rd_q != VEC_C) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= base_q + ADDR_W'(rd_q);
            rd_q       <= rd_q + 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  base_q   <= base_addr;
                  drain_q  <= drain;
                  replay_q <= replay;
                  busy_q   <= 1'b1;
                  st_q     <= '0;
                  if (replay) begin
                     state_q <= S_GAP;
                  end else begin
                     state_q    <= S_CLEAR;
                     ctl_q      <= CTL_CLEAR;
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= base_addr;
                     rd_q       <= CW'(1);
                  end
               end
            end
            S_CLEAR: state_q <= S_LOAD;
            S_LOAD: begin
               // Data in flight is presented one cycle after it returns.
               if (vld_q) begin
                  ctl_q   <= CTL_STORE;
                  ib_in_q <= mem_data;
                  st_q    <= st_q + 1'b1;
               end else if (st_q == VEC_C) begin
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               if (drain_q || replay_q) begin
                  state_q <= S_DRAIN;
                  ctl_q   <= CTL_OUT;
                  st_q    <= CW'(1);
               end else begin
                  state_q <= S_FIN;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (st_q == VEC_C) begin
                  state_q <= S_FIN;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  ctl_q <= CTL_OUT;
                  st_q  <= st_q + 1'b1;
               end
            end
            S_FIN: begin
               state_q <= S_IDLE;
               rd_q    <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign ib_ctl   = ctl_q;
   assign ib_in    = ib_in_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_ib_feeder.sv
// Directed self-checking bench for ib_feeder with a synchronous memory and a
// behavioural 4-lane input buffer.
module tb_ib_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  base_addr = '0;
   logic        drain = 1'b0;
   logic        replay = 1'b0;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data = '0;
   logic [1:0]  ib_ctl;
   logic [15:0] ib_in;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [256];
   logic [15:0] bbuf [4];
   int          bptr = 0;
   logic [15:0] bout = '0;

   logic [1:0]  a_ctl  [16];
   logic [15:0] a_in   [16];
   logic [15:0] a_bout [16];
   logic [7:0]  a_addr [16];
   logic        a_rd   [16];
   logic        a_done [16];
   logic        a_busy [16];

   ib_feeder #(.WIDTH(16), .VECTOR(4), .ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .drain(drain), .replay(replay), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .ib_ctl(ib_ctl), .ib_in(ib_in), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   // Buffer model: address returns to 0 on idle/clear, output is one cycle late.
   always @(posedge clk) begin
      bout <= '0;
      case (ib_ctl)
         2'd1: begin bbuf[bptr] <= ib_in; bptr <= (bptr + 1) % 4; end
         2'd2: begin bout <= bbuf[bptr]; bptr <= (bptr + 1) % 4; end
         default: bptr <= 0;
      endcase
   end

   task automatic run(input logic [7:0] b, input logic d, input logic r, input int n,
                      input int p1, input int p2, input int rc);
      @(negedge clk);
      base_addr = b; drain = d; replay = r; start = 1'b1;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         a_ctl[c] = ib_ctl; a_in[c] = ib_in; a_bout[c] = bout; a_addr[c] = mem_addr;
         a_rd[c] = mem_rd; a_done[c] = done; a_busy[c] = busy;
         start = (c == p1 || c == p2);
         rst = (c == rc);
      end
      start = 1'b0; rst = 1'b0; drain = 1'b0; replay = 1'b0;
   endtask

   task automatic set_mem(input logic [7:0] b, input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
      logic [7:0] a;
      a = b;
      mem[a] = w0; a = a + 8'd1;
      mem[a] = w1; a = a + 8'd1;
      mem[a] = w2; a = a + 8'd1;
      mem[a] = w3;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({ib_ctl, ib_in, mem_rd, mem_addr, busy, done} !== 29'd0) begin
         errors++;
         $display("FAIL reset_outputs: got ctl=%0d in=%h rd=%b addr=%h busy=%b done=%b required all 0",
                  ib_ctl, ib_in, mem_rd, mem_addr, busy, done);
      end
   endtask

   task automatic check_load(input string nm, input logic [7:0] b, input logic [15:0] w0,
                             input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
      logic [1:0]  e_ctl [8];
      logic [15:0] e_in  [8];
      logic [7:0]  e_a;
      e_ctl = '{2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
      e_in  = '{16'h0, 16'h0, w0, w1, w2, w3, 16'h0, 16'h0};
      for (int c = 0; c < 8; c++) begin
         checks++;
         if (a_ctl[c] !== e_ctl[c] || a_in[c] !== e_in[c]) begin
            errors++;
            $display("FAIL %s_ctl_in c%0d: got ctl=%0d in=%h required ctl=%0d in=%h",
                     nm, c, a_ctl[c], a_in[c], e_ctl[c], e_in[c]);
         end
         checks++;
         if (a_done[c] !== (c == 7) || a_busy[c] !== (c != 7)) begin
            errors++;
            $display("FAIL %s_done_busy c%0d: got done=%b busy=%b required done=%b busy=%b",
                     nm, c, a_done[c], a_busy[c], c == 7, c != 7);
         end
      end
      e_a = b;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (a_rd[c] !== (c < 4) || a_addr[c] !== e_a) begin
            errors++;
            $display("FAIL %s_read c%0d: got rd=%b addr=%h required rd=%b addr=%h",
                     nm, c, a_rd[c], a_addr[c], c < 4, e_a);
         end
         if (c < 3) e_a = e_a + 8'd1;
      end
   endtask

   task automatic test_load;
      set_mem(8'h10, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
      run(8'h10, 1'b0, 1'b0, 8, -1, -1, -1);
      check_load("load", 8'h10, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bbuf[i] !== 16'(16'h0011 * (i + 1))) begin
            errors++;
            $display("FAIL load_buffer[%0d]: got %h required %h", i, bbuf[i], 16'(16'h0011 * (i + 1)));
         end
      end
   endtask

   task automatic test_drain;
      logic [1:0] e_ctl [12];
      e_ctl = '{2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      run(8'h10, 1'b1, 1'b0, 12, -1, -1, -1);
      for (int c = 0; c < 12; c++) begin
         checks++;
         if (a_ctl[c] !== e_ctl[c] || a_done[c] !== (c == 11)) begin
            errors++;
            $display("FAIL drain_ctl c%0d: got ctl=%0d done=%b required ctl=%0d done=%b",
                     c, a_ctl[c], a_done[c], e_ctl[c], c == 11);
         end
      end
      for (int c = 8; c < 12; c++) begin
         checks++;
         if (a_bout[c] !== 16'(16'h0011 * (c - 7))) begin
            errors++;
            $display("FAIL drain_bufout c%0d: got %h required %h", c, a_bout[c], 16'(16'h0011 * (c - 7)));
         end
      end
   endtask

   task automatic test_replay;
      logic [1:0] e_ctl [6];
      e_ctl = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      set_mem(8'h10, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
      run(8'h10, 1'b0, 1'b1, 6, -1, -1, -1);
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (a_ctl[c] !== e_ctl[c] || a_rd[c] !== 1'b0 || a_in[c] !== 16'h0 || a_done[c] !== (c == 5)) begin
            errors++;
            $display("FAIL replay c%0d: got ctl=%0d rd=%b in=%h done=%b required ctl=%0d rd=0 in=0 done=%b",
                     c, a_ctl[c], a_rd[c], a_in[c], a_done[c], e_ctl[c], c == 5);
         end
      end
      for (int c = 2; c < 6; c++) begin
         checks++;
         if (a_bout[c] !== 16'(16'h0011 * (c - 1))) begin
            errors++;
            $display("FAIL replay_bufout c%0d: got %h required %h", c, a_bout[c], 16'(16'h0011 * (c - 1)));
         end
      end
   endtask

   task automatic test_wrap;
      set_mem(8'hFE, 16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4);
      run(8'hFE, 1'b0, 1'b0, 8, -1, -1, -1);
      check_load("wrap", 8'hFE, 16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4);
   endtask

   task automatic test_ignored_start;
      set_mem(8'h10, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
      run(8'h10, 1'b0, 1'b0, 9, 3, 7, -1);
      check_load("ignore", 8'h10, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
      checks++;
      if (a_ctl[8] !== 2'd0 || a_busy[8] !== 1'b0 || a_rd[8] !== 1'b0) begin
         errors++;
         $display("FAIL ignore_after_fin: got ctl=%0d busy=%b rd=%b required 0 0 0",
                  a_ctl[8], a_busy[8], a_rd[8]);
      end
   endtask

   task automatic test_mid_reset;
      run(8'h10, 1'b0, 1'b0, 6, -1, -1, 4);
      checks++;
      if (a_ctl[4] !== 2'd1 || a_in[4] !== 16'h0033) begin
         errors++;
         $display("FAIL midrst_pre: got ctl=%0d in=%h required 1 0033", a_ctl[4], a_in[4]);
      end
      checks++;
      if ({a_ctl[5], a_in[5], a_rd[5], a_addr[5], a_busy[5], a_done[5]} !== 29'd0) begin
         errors++;
         $display("FAIL midrst_post: got ctl=%0d in=%h rd=%b addr=%h busy=%b done=%b required all 0",
                  a_ctl[5], a_in[5], a_rd[5], a_addr[5], a_busy[5], a_done[5]);
      end
      run(8'h10, 1'b0, 1'b0, 8, -1, -1, -1);
      check_load("restart", 8'h10, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      for (int i = 0; i < 4; i++) bbuf[i] = '0;
      test_reset;
      test_load;
      test_drain;
      test_replay;
      test_wrap;
      test_ignored_start;
      test_mid_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
